seg_scan_display: RTL and testbench



---
 rtl/seg_scan_display_pkg.sv | 19 +
 rtl/seg_scan_display_if.sv | 23 ++
 rtl/seg_scan_display_font_dec.sv | 13 +
 rtl/seg_scan_display.sv | 141 ++++++++++++++
 tb/tb_seg_scan_display.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared segment constants and the hex font for the scanned 7-segment driver.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_DASH = 7'h3F;

    localparam seg_t SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t seg_font(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Value/strobe inputs and scanned pin outputs of the display driver.
// master = register side driving values, slave = the display driver itself.
interface seg_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic                  valid;
    logic                  blink_en;
    logic [6:0]            seg_o;
    logic [DIGITS-1:0]     dig_o;
    logic                  commit_o;

    modport master (
        output load, data, valid, blink_en,
        input  seg_o, dig_o, commit_o
    );

    modport slave (
        input  load, data, valid, blink_en,
        output seg_o, dig_o, commit_o
    );
endinterface

// File: rtl/seg_scan_display_font_dec.sv
// Nibble to active-low segment pattern; an invalid value shows a dash.
// Purely combinational, no backpressure.
module seg_font_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       valid,
    output seg_t       seg
);

    assign seg = valid ? seg_font(nibble) : SEG_DASH;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver with frame-aligned commit, slot blanking and blink.
// Outputs registered one cycle after counter state; load accepted every cycle. Option: SEG_LZB_EN.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_display_if.slave  bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW    = 4 * DIGITS;

    logic [PRE_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic [FRM_W-1:0]  frm_cnt;
    logic              blink_on;

    logic [DW-1:0]     disp_dat;
    logic              disp_vld;
    logic [DW-1:0]     pend_dat;
    logic              pend_vld;
    logic              pend_flag;

    seg_t              seg_q;
    logic [DIGITS-1:0] dig_q;
    logic              commit_q;

    logic              slot_wrap;
    logic              frame_end;
    logic [3:0]        cur_nib;
    seg_t              font_seg;
    logic              lz_blank;
    seg_t              seg_nxt;
    logic [DIGITS-1:0] dig_nxt;

    assign slot_wrap = (presc == PRE_W'(SCAN_DIV - 1));
    assign frame_end = slot_wrap && (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) cur_nib = disp_dat[i*4 +: 4];
        end
    end

    seg_font_dec u_font (
        .nibble (cur_nib),
        .valid  (disp_vld),
        .seg    (font_seg)
    );

`ifdef SEG_LZB_EN
    // lz_run[i]: every nibble from the top down to i is zero
    logic [DIGITS-1:0] lz_run;
    always_comb begin
        lz_run = '0;
        lz_run[DIGITS-1] = (disp_dat[DW-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz_run[i] = lz_run[i+1] && (disp_dat[i*4 +: 4] == 4'h0);
        end
    end
    assign lz_blank = disp_vld && (idx != '0) && lz_run[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_nxt = SEG_OFF;
        dig_nxt = '1;
        if ((presc >= PRE_W'(BLANK_CYC)) && !(bus.blink_en && !blink_on)) begin
            dig_nxt = ~(DIGITS'(1) << idx);
            seg_nxt = lz_blank ? SEG_OFF : font_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            frm_cnt   <= '0;
            blink_on  <= 1'b1;
            disp_dat  <= '0;
            disp_vld  <= 1'b0;
            pend_dat  <= '0;
            pend_vld  <= 1'b0;
            pend_flag <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= '1;
            commit_q  <= 1'b0;
        end else begin
            seg_q    <= seg_nxt;
            dig_q    <= dig_nxt;
            commit_q <= 1'b0;

            if (slot_wrap) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (frame_end && pend_flag) begin
                disp_dat  <= pend_dat;
                disp_vld  <= pend_vld;
                pend_flag <= 1'b0;
                commit_q  <= 1'b1;
            end
            // A coincident load lands after the commit above, so it stays pending
            if (bus.load) begin
                pend_dat  <= bus.data;
                pend_vld  <= bus.valid;
                pend_flag <= 1'b1;
            end

            if (!bus.blink_en) begin
                frm_cnt  <= '0;
                blink_on <= 1'b1;
            end else if (frame_end) begin
                if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frm_cnt  <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.seg_o    = seg_q;
    assign bus.dig_o    = dig_q;
    assign bus.commit_o = commit_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a per-cycle reference derived from elapsed time
// since reset predicts every output; a separate monitor compares each cycle.
module tb_seg_scan_display;

    localparam int D     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = SD * D;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       commit;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_display_if #(.DIGITS(D)) bus();

    seg_scan_display #(
        .DIGITS       (D),
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int model_commits = 0;
    int dut_commits = 0;
    exp_t q[$];

    // reference state: cycles since reset release plus register contents
    int          t;
    logic [15:0] disp, pend;
    bit          dv, pv, pf;
    int          bcount;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit next_fe();
        return (t % FRAME) == FRAME - 1;
    endfunction

    function automatic bit phase_on();
        return ((bcount / BF) % 2) == 0;
    endfunction

    task automatic model_reset();
        t = 0; disp = '0; pend = '0; dv = 0; pv = 0; pf = 0; bcount = 0;
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.seg = 7'h7F; e.dig = 4'hF; e.commit = 1'b0; e.t = -1;
        q.push_back(e);
    endtask

    task automatic model_step();
        exp_t e;
        int   p, ix;
        bit   fe;
        p  = t % SD;
        ix = (t / SD) % D;
        fe = next_fe();
        e.seg = 7'h7F; e.dig = 4'hF; e.commit = fe && pf; e.t = t;
        if (p >= BC && !(bus.blink_en && !phase_on())) begin
            e.dig = ~(4'b0001 << ix);
            if (!dv) e.seg = 7'h3F;
            else if (LZB && ix != 0 && (disp >> (4 * ix)) == 16'h0) e.seg = 7'h7F;
            else e.seg = font(disp[4*ix +: 4]);
        end
        q.push_back(e);
        if (fe && pf) begin
            disp = pend; dv = pv; pf = 0;
            model_commits++;
        end
        if (bus.load) begin
            pend = bus.data; pv = bus.valid; pf = 1;
        end
        if (!bus.blink_en) bcount = 0;
        else if (fe) bcount++;
        t++;
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic v, input logic be);
        @(negedge clk);
        bus.load = ld; bus.data = d; bus.valid = v; bus.blink_en = be;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string name);
        tests++;
        if (bus.seg_o !== 7'h7F || bus.dig_o !== 4'hF || bus.commit_o !== 1'b0) begin
            fails++;
            $display("FAIL %s got seg=%h dig=%b commit=%b need seg=7f dig=1111 commit=0",
                     name, bus.seg_o, bus.dig_o, bus.commit_o);
        end
    endtask

    // Monitor: compares the DUT output of every cycle against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.commit_o === 1'b1) dut_commits++;
                if (bus.seg_o !== e.seg || bus.dig_o !== e.dig || bus.commit_o !== e.commit) begin
                    fails++;
                    $display("FAIL slot t=%0d got seg=%h dig=%b commit=%b need seg=%h dig=%b commit=%b",
                             e.t, bus.seg_o, bus.dig_o, bus.commit_o, e.seg, e.dig, e.commit);
                end
            end
        end
    end

    initial begin
        int guard;
        logic be;
        bus.load = 1'b0; bus.data = '0; bus.valid = 1'b0; bus.blink_en = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_step();

        // idle scan: dashes in every slot
        idle(2 * FRAME);

        // mid-frame load shows only after the frame end
        while (t % FRAME != 9) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h12AF, 1'b1, 1'b0);
        idle(2 * FRAME);

        // two loads in one frame: last one wins
        while (t % FRAME != 3) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h1111, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 16'h2222, 1'b1, 1'b0);
        idle(2 * FRAME);

        // load exactly on a frame-end cycle while another value is pending
        while (t % FRAME != 10) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        while (!next_fe()) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'hC0DE, 1'b1, 1'b0);
        idle(3 * FRAME);

        // blink for several half-periods, then drop it while blanked
        for (int i = 0; i < 5 * BF * FRAME; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
        guard = 0;
        while (!(!phase_on() && (t % SD) == 4) && guard < 1000) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (guard >= 1000) begin
            fails++;
            $display("FAIL blink_off_phase never reached within %0d cycles", guard);
        end
        idle(FRAME);

        // leading-zero patterns and zero
        step(1'b1, 16'h0050, 1'b1, 1'b0);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        idle(2 * FRAME);

        // randomized loads, values and blink toggling
        be = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            if ($urandom_range(0, 299) == 0) be = ~be;
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            step(($urandom_range(0, 19) == 0), d, ($urandom_range(0, 7) != 0), be);
        end

        // async reset in the active part of a slot
        step(1'b1, 16'h8888, 1'b1, 1'b0);
        idle(2 * FRAME);
        while (t % SD != 4) step(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset_mid_slot");
        q.delete();
        model_reset();
        push_reset_exp();
        repeat (2) begin
            @(negedge clk);
            push_reset_exp();
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.load = 1'b0; bus.data = '0; bus.valid = 1'b0; bus.blink_en = 1'b0;
        model_step();
        idle(FRAME);
        step(1'b1, 16'h3A0C, 1'b1, 1'b0);
        idle(2 * FRAME);

        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending predictions need 0", q.size());
        end
        tests++;
        if (dut_commits != model_commits) begin
            fails++;
            $display("FAIL commit_count got %0d need %0d", dut_commits, model_commits);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
